// File: rtl/synchronizer.sv
// synchronizer: I2S receive front-end. Brings the asynchronous _sck/_sd/_ws
// pins into the clk domain through equal-depth flop chains. It also produces a
// one-clk pulse, sck_transition, on each rising edge of the synchronized sck.
// Optional macro SCK_DEGLITCH_EN adds a consecutive-sample glitch filter on
// sck, plus matching delay lines on sd and ws.
module synchronizer #(
    parameter int SYNC_STAGES = 2,   // legal 2..4
    parameter int FILTER_LEN  = 4    // legal 2..15, used with SCK_DEGLITCH_EN
) (
    input  logic clk,
    input  logic rst_n,
    input  logic _sck,
    input  logic _sd,
    input  logic _ws,
    output logic sck,
    output logic sck_transition,
    output logic sd,
    output logic ws
);

    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] sd_sync;
    logic [SYNC_STAGES-1:0] ws_sync;
    logic                   sck_d;

    // Three chains of identical depth, so pin-level skew between sck and sd/ws is preserved
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync <= '0;
            sd_sync  <= '0;
            ws_sync  <= '0;
        end else begin
            sck_sync <= {sck_sync[SYNC_STAGES-2:0], _sck};
            sd_sync  <= {sd_sync[SYNC_STAGES-2:0], _sd};
            ws_sync  <= {ws_sync[SYNC_STAGES-2:0], _ws};
        end
    end

`ifdef SCK_DEGLITCH_EN
    logic                  sck_filt;
    logic [3:0]            filt_cnt;
    logic [FILTER_LEN-1:0] sd_dly;
    logic [FILTER_LEN-1:0] ws_dly;

    // Filtered sck only follows the synchronized value after FILTER_LEN consecutive disagreeing clks
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_filt <= 1'b0;
            filt_cnt <= 4'd0;
        end else if (sck_sync[SYNC_STAGES-1] == sck_filt) begin
            filt_cnt <= 4'd0;
        end else if (filt_cnt == 4'(FILTER_LEN - 1)) begin
            sck_filt <= sck_sync[SYNC_STAGES-1];
            filt_cnt <= 4'd0;
        end else begin
            filt_cnt <= filt_cnt + 4'd1;
        end
    end

    // Delay sd/ws by the filter's decision latency to keep them aligned with the filtered sck
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sd_dly <= '0;
            ws_dly <= '0;
        end else begin
            sd_dly <= {sd_dly[FILTER_LEN-2:0], sd_sync[SYNC_STAGES-1]};
            ws_dly <= {ws_dly[FILTER_LEN-2:0], ws_sync[SYNC_STAGES-1]};
        end
    end

    assign sck = sck_filt;
    assign sd  = sd_dly[FILTER_LEN-1];
    assign ws  = ws_dly[FILTER_LEN-1];
`else
    assign sck = sck_sync[SYNC_STAGES-1];
    assign sd  = sd_sync[SYNC_STAGES-1];
    assign ws  = ws_sync[SYNC_STAGES-1];
`endif

    // One-clk history of sck for rising-edge detection; reset low so a high sck at release still pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_d <= 1'b0;
        end else begin
            sck_d <= sck;
        end
    end

    // Both operands are flop outputs, so the pulse has no path from the raw pins
    assign sck_transition = sck & ~sck_d;

endmodule

// File: tb/tb_synchronizer.sv
// tb_synchronizer: randomized and directed stimulus for synchronizer. The
// expected outputs come from a sample-history model, checked every clk, plus
// literal expectations for latency, pulse count, recovered words and reset.
module tb_synchronizer;

    localparam int S  = 2;
    localparam int FL = 4;
`ifdef SCK_DEGLITCH_EN
    localparam int EXP_LAT = S + FL;
`else
    localparam int EXP_LAT = S;
`endif
    localparam int H = 10;

    logic clk = 1'b0;
    logic rst_n;
    logic p_sck, p_sd, p_ws;
    logic sck, sck_transition, sd, ws;

    int checks = 0;
    int failures = 0;

    synchronizer #(.SYNC_STAGES(S), .FILTER_LEN(FL)) dut (
        .clk(clk), .rst_n(rst_n),
        ._sck(p_sck), ._sd(p_sd), ._ws(p_ws),
        .sck(sck), .sck_transition(sck_transition), .sd(sd), .ws(ws)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: history of pin samples taken at each clk edge since reset release
    logic hs[$], hd[$], hw[$];
    logic fh[$];

    function automatic logic syn_s(int m);
        if (m < S) return 1'b0;
        return hs[m-S];
    endfunction
    function automatic logic syn_d(int m);
        if (m < S) return 1'b0;
        return hd[m-S];
    endfunction
    function automatic logic syn_w(int m);
        if (m < S) return 1'b0;
        return hw[m-S];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs.delete(); hd.delete(); hw.delete();
            fh.delete(); fh.push_back(1'b0);
        end else begin
            int n;
            logic f_old, flip;
            hs.push_back(p_sck); hd.push_back(p_sd); hw.push_back(p_ws);
            n = hs.size();
            f_old = fh[n-1];
            flip = (n >= FL);
            for (int j = 1; j <= FL; j++)
                if (syn_s(n-j) == f_old) flip = 1'b0;
            fh.push_back(flip ? ~f_old : f_old);
        end
    end

    // Per-cycle compare against the model
    always @(negedge clk) begin
        int n;
        logic e_sck, e_prev, e_sd, e_ws;
        n = hs.size();
        if (!rst_n) begin
            e_sck = 0; e_prev = 0; e_sd = 0; e_ws = 0;
        end else begin
`ifdef SCK_DEGLITCH_EN
            e_sck  = fh[n];
            e_prev = (n >= 1) ? fh[n-1] : 1'b0;
            e_sd   = syn_d(n - FL);
            e_ws   = syn_w(n - FL);
`else
            e_sck  = syn_s(n);
            e_prev = syn_s(n - 1);
            e_sd   = syn_d(n);
            e_ws   = syn_w(n);
`endif
        end
        chk("cyc_sck", 32'(sck), 32'(e_sck));
        chk("cyc_sd", 32'(sd), 32'(e_sd));
        chk("cyc_ws", 32'(ws), 32'(e_ws));
        chk("cyc_trans", 32'(sck_transition), 32'(e_sck & ~e_prev));
    end

    int  pulse_cycles = 0;
    bit  cap_en = 0;
    logic cap_sd[$], cap_ws[$];

    always @(negedge clk) begin
        if (sck_transition) pulse_cycles++;
        if (cap_en && sck_transition) begin
            cap_sd.push_back(sd);
            cap_ws.push_back(ws);
        end
    end

    task automatic step(input int k);
        repeat (k) @(posedge clk);
        #2;
    endtask

    logic [15:0] words [4];
    logic bits [65];
    logic wsb [65];

    task automatic send_slot(input int i);
        p_sck = 1'b1;
        step(3);
        p_sd = bits[i];
        p_ws = wsb[i];
        step(H - 3);
        p_sck = 1'b0;
        step(H);
    endtask

    initial begin
        int lat;
        logic [15:0] wv, wsv;
        logic [15:0] ws_exp [4];

        words[0] = 16'hAAAA; words[1] = 16'hFFFF; words[2] = 16'h1478; words[3] = 16'hA3B9;
        ws_exp[0] = 16'h0001; ws_exp[1] = 16'hFFFE; ws_exp[2] = 16'h0001; ws_exp[3] = 16'hFFFE;
        for (int k = 0; k < 64; k++) begin
            wv = words[k/16];
            bits[k] = wv[15 - (k % 16)];
            wsb[k]  = 1'(((k + 1) / 16) % 2);
        end
        bits[64] = 1'b0;
        wsb[64]  = 1'b0;

        // Reset held with toggling pins
        rst_n = 1'b0;
        p_sck = 0; p_sd = 0; p_ws = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            p_sck = 1'($urandom_range(1));
            p_sd  = 1'($urandom_range(1));
            p_ws  = 1'($urandom_range(1));
        end
        chk("rst_sck", 32'(sck), 32'h0);
        chk("rst_trans", 32'(sck_transition), 32'h0);
        rst_n = 1'b1;

        // Randomized pin activity with varied hold lengths
        for (int i = 0; i < 3000; i++) begin
            step(1);
            if ($urandom_range(7) == 0) p_sck = ~p_sck;
            if ($urandom_range(3) == 0) p_sd = 1'($urandom_range(1));
            if ($urandom_range(5) == 0) p_ws = 1'($urandom_range(1));
        end
        p_sck = 0; p_sd = 0; p_ws = 0;
        step(20);

        // Rising-edge latency and pulse count
        p_sck = 1'b1;
        lat = 0;
        while (lat < 50) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (sck_transition) break;
        end
        chk("edge_latency", 32'(lat), 32'(EXP_LAT));
        step(40 - lat);
        p_sck = 1'b0;
        step(40);
        pulse_cycles = 0;
        for (int i = 0; i < 5; i++) begin
            p_sck = 1'b1; step(40);
            p_sck = 1'b0; step(40);
        end
        step(10);
        chk("pulse_cycles", 32'(pulse_cycles), 32'd5);

        // Word capture: data changes shortly after each sck rise
        cap_en = 1;
        for (int i = 0; i < 65; i++) send_slot(i);
        step(10);
        cap_en = 0;
        chk("cap_count", 32'(cap_sd.size()), 32'd65);
        if (cap_sd.size() == 65) begin
            for (int w = 0; w < 4; w++) begin
                wv = '0; wsv = '0;
                for (int b = 0; b < 16; b++) begin
                    wv  = {wv[14:0], cap_sd[1 + 16*w + b]};
                    wsv = {wsv[14:0], cap_ws[1 + 16*w + b]};
                end
                chk($sformatf("word%0d", w), 32'(wv), 32'(words[w]));
                chk($sformatf("wsvec%0d", w), 32'(wsv), 32'(ws_exp[w]));
            end
        end

        // Async reset during the 5th bit while sck is high
        p_sck = 0; p_sd = 0; p_ws = 0;
        step(20);
        for (int i = 0; i < 4; i++) send_slot(i);
        p_sck = 1'b1;
        step(8);
        #1;
        chk("pre_rst_sck", 32'(sck), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_sck", 32'(sck), 32'h0);
        chk("async_rst_sd", 32'(sd), 32'h0);
        chk("async_rst_ws", 32'(ws), 32'h0);
        chk("async_rst_trans", 32'(sck_transition), 32'h0);
        step(3);
        rst_n = 1'b1;
        step(H);
        p_sck = 1'b0;
        step(H);
        for (int i = 5; i < 24; i++) send_slot(i);

`ifdef SCK_DEGLITCH_EN
        // Short glitch on _sck must be swallowed by the filter
        p_sck = 0;
        step(20);
        pulse_cycles = 0;
        p_sck = 1'b1;
        step(2);
        p_sck = 1'b0;
        step(20);
        chk("glitch_pulses", 32'(pulse_cycles), 32'd0);
        chk("glitch_sck", 32'(sck), 32'h0);
`endif

        step(5);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
